// File: rtl/card_auth_session_if.sv
// Card reader / keypad / transaction unit / provisioning bundle for the card session controller.
interface card_auth_session_if #(
  parameter int unsigned card_width     = 4,
  parameter int unsigned password_width = 16,
  parameter int unsigned balance_width  = 20
);
  logic                      card_in;
  logic [card_width-1:0]     card_number;
  logic                      pin_valid;
  logic [password_width-1:0] password_input;
  logic                      op_done;
  logic [balance_width-1:0]  updated_balance;
  logic                      prov_we;
  logic [card_width-1:0]     prov_card;
  logic [password_width-1:0] prov_password;
  logic [balance_width-1:0]  prov_balance;
  logic [balance_width-1:0]  balance;
  logic                      auth_ok;
  logic                      wrong_psw;
  logic                      card_locked;
  logic                      invalid_card;
  logic                      timeout;
  logic [2:0]                tries_left;

  modport master (
    output card_in, card_number, pin_valid, password_input, op_done, updated_balance,
           prov_we, prov_card, prov_password, prov_balance,
    input  balance, auth_ok, wrong_psw, card_locked, invalid_card, timeout, tries_left
  );

  modport slave (
    input  card_in, card_number, pin_valid, password_input, op_done, updated_balance,
           prov_we, prov_card, prov_password, prov_balance,
    output balance, auth_ok, wrong_psw, card_locked, invalid_card, timeout, tries_left
  );
endinterface

// File: rtl/card_auth_session.sv
// Card/PIN session controller: PIN authentication with lockout, inactivity timeout,
// per-user balance store with runtime provisioning.
module card_auth_session #(
  parameter int unsigned card_width     = 4,
  parameter int unsigned password_width = 16,
  parameter int unsigned balance_width  = 20,
  parameter int unsigned users_num      = 10,
  parameter int unsigned max_tries      = 3,
  parameter int unsigned timeout_cycles = 1000
) (
  input logic               clk,
  input logic               rst,
  card_auth_session_if.slave bus
);

  localparam int unsigned depth       = 1 << card_width;
  localparam int unsigned timer_width = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam int unsigned tries_width = 3;

  typedef enum logic [1:0] {IDLE, WAIT_PIN, SESSION, EJECT} state_t;

  state_t                    state_q, state_d;
  logic [card_width-1:0]     cur_card_q, cur_card_d;
  logic [timer_width-1:0]    timer_q, timer_d;
  logic [balance_width-1:0]  balance_q, balance_d;
  logic                      auth_ok_q, auth_ok_d;
  logic                      wrong_psw_q, wrong_psw_d;
  logic                      timeout_q, timeout_d;
  logic                      card_locked_q, card_locked_d;
  logic                      invalid_card_q, invalid_card_d;
  logic [tries_width-1:0]    tries_left_q, tries_left_d;

  logic [password_width-1:0] pwd_mem [depth];
  logic [balance_width-1:0]  bal_mem [depth];
  logic [depth-1:0]          lock_q;
  logic [depth-1:0][tries_width-1:0] fail_q;

  logic                      fail_inc, fail_clr, lock_set, bal_we, leave;
  logic                      prov_ok, prov_hit_cur, timer_done;
  logic [tries_width-1:0]    fail_next;

  // Cards at or above users_num have no database entry.
  function automatic logic card_valid(input logic [card_width-1:0] c);
    return {1'b0, c} < (card_width+1)'(users_num);
  endfunction

  assign prov_ok      = bus.prov_we && card_valid(bus.prov_card);
  assign prov_hit_cur = prov_ok && (bus.prov_card == cur_card_q);
  assign timer_done   = (timer_q == timer_width'(timeout_cycles - 1));
  assign fail_next    = fail_q[cur_card_q] + tries_width'(1);

  always_comb begin
    state_d        = state_q;
    cur_card_d     = cur_card_q;
    timer_d        = timer_q;
    balance_d      = balance_q;
    auth_ok_d      = auth_ok_q;
    wrong_psw_d    = 1'b0;
    timeout_d      = 1'b0;
    card_locked_d  = card_locked_q;
    invalid_card_d = invalid_card_q;
    tries_left_d   = tries_left_q;
    fail_inc       = 1'b0;
    fail_clr       = 1'b0;
    lock_set       = 1'b0;
    bal_we         = 1'b0;
    leave          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.card_in) begin
          cur_card_d = bus.card_number;
          if (!card_valid(bus.card_number)) begin
            state_d        = EJECT;
            invalid_card_d = 1'b1;
          end else if (lock_q[bus.card_number]) begin
            state_d       = EJECT;
            card_locked_d = 1'b1;
          end else begin
            state_d      = WAIT_PIN;
            timer_d      = '0;
            tries_left_d = tries_width'(max_tries) - fail_q[bus.card_number];
          end
        end
      end

      WAIT_PIN: begin
        if (!bus.card_in) begin
          leave = 1'b1;
        end else if (bus.pin_valid) begin
          // A PIN attempt outranks a timeout expiring on the same cycle.
          timer_d = '0;
          if (bus.password_input == pwd_mem[cur_card_q]) begin
            state_d      = SESSION;
            auth_ok_d    = 1'b1;
            balance_d    = bal_mem[cur_card_q];
            fail_clr     = 1'b1;
            tries_left_d = tries_width'(max_tries);
          end else begin
            wrong_psw_d  = 1'b1;
            fail_inc     = 1'b1;
            tries_left_d = tries_width'(max_tries) - fail_next;
            if (fail_next == tries_width'(max_tries)) begin
              lock_set      = 1'b1;
              state_d       = EJECT;
              card_locked_d = 1'b1;
            end
          end
        end else if (timer_done) begin
          timeout_d = 1'b1;
          state_d   = EJECT;
        end else begin
          timer_d = timer_q + timer_width'(1);
        end
      end

      SESSION: begin
        // A commit still lands when the card is pulled on the same cycle.
        bal_we = bus.op_done;
        if (bus.op_done) begin
          balance_d = bus.updated_balance;
          timer_d   = '0;
        end
        if (!bus.card_in) begin
          leave = 1'b1;
        end else if (!bus.op_done) begin
          if (timer_done) begin
            timeout_d = 1'b1;
            state_d   = EJECT;
            auth_ok_d = 1'b0;
            balance_d = '0;
          end else begin
            timer_d = timer_q + timer_width'(1);
          end
        end
      end

      EJECT: begin
        if (!bus.card_in) leave = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (leave) begin
      state_d        = IDLE;
      timer_d        = '0;
      balance_d      = '0;
      auth_ok_d      = 1'b0;
      card_locked_d  = 1'b0;
      invalid_card_d = 1'b0;
      tries_left_d   = '0;
    end

    // Reprovisioning the active card is reflected on the session balance immediately.
    if (state_d == SESSION && prov_hit_cur) balance_d = bus.prov_balance;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_card_q     <= '0;
      timer_q        <= '0;
      balance_q      <= '0;
      auth_ok_q      <= 1'b0;
      wrong_psw_q    <= 1'b0;
      timeout_q      <= 1'b0;
      card_locked_q  <= 1'b0;
      invalid_card_q <= 1'b0;
      tries_left_q   <= '0;
    end else begin
      state_q        <= state_d;
      cur_card_q     <= cur_card_d;
      timer_q        <= timer_d;
      balance_q      <= balance_d;
      auth_ok_q      <= auth_ok_d;
      wrong_psw_q    <= wrong_psw_d;
      timeout_q      <= timeout_d;
      card_locked_q  <= card_locked_d;
      invalid_card_q <= invalid_card_d;
      tries_left_q   <= tries_left_d;
    end
  end

  // Lockout bookkeeping; provisioning a card always gives it a clean slate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
      fail_q <= '0;
    end else begin
      if (fail_clr) fail_q[cur_card_q] <= '0;
      if (fail_inc) fail_q[cur_card_q] <= fail_next;
      if (lock_set) lock_q[cur_card_q] <= 1'b1;
      if (prov_ok) begin
        lock_q[bus.prov_card] <= 1'b0;
        fail_q[bus.prov_card] <= '0;
      end
    end
  end

  // User database; contents survive reset and are loaded only by provisioning.
  always_ff @(posedge clk) begin
    if (prov_ok) begin
      pwd_mem[bus.prov_card] <= bus.prov_password;
      bal_mem[bus.prov_card] <= bus.prov_balance;
    end
    if (bal_we && !prov_hit_cur) bal_mem[cur_card_q] <= bus.updated_balance;
  end

  assign bus.balance      = balance_q;
  assign bus.auth_ok      = auth_ok_q;
  assign bus.wrong_psw    = wrong_psw_q;
  assign bus.card_locked  = card_locked_q;
  assign bus.invalid_card = invalid_card_q;
  assign bus.timeout      = timeout_q;
  assign bus.tries_left   = tries_left_q;

endmodule

// File: tb/tb_card_auth_session.sv
// Bench for card_auth_session: directed vector table, multi-cycle corner sequences and
// random traffic against a session-level reference model.
module tb_card_auth_session;

  localparam int n_users  = 10;
  localparam int mt       = 3;
  localparam int to_cyc   = 1000;
  localparam int bad_pin  = 16'h0bad;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  card_auth_session_if #(.card_width(4), .password_width(16), .balance_width(20)) bus ();

  card_auth_session #(
    .card_width(4), .password_width(16), .balance_width(20),
    .users_num(n_users), .max_tries(mt), .timeout_cycles(to_cyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the customer sees, phase by phase.
  localparam int P_IDLE = 0, P_PIN = 1, P_SESS = 2, P_OUT = 3;
  int          ph, cur, idle;
  logic [15:0] m_pwd [16];
  logic [19:0] m_bal [16];
  int          m_fail [16];
  bit          m_lock [16];
  logic [19:0] x_bal;
  bit          x_auth, x_wrong, x_lock, x_inv, x_to;
  int          x_tries;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; cur = 0; idle = 0;
    x_bal = '0; x_auth = 0; x_wrong = 0; x_lock = 0; x_inv = 0; x_to = 0; x_tries = 0;
    for (int i = 0; i < 16; i++) begin m_fail[i] = 0; m_lock[i] = 0; end
  endtask

  task automatic card_out();
    ph = P_IDLE; idle = 0;
    x_bal = '0; x_auth = 0; x_lock = 0; x_inv = 0; x_tries = 0;
  endtask

  task automatic model_step();
    bit prov_ok, commit;
    int pc;
    pc      = int'(bus.prov_card);
    prov_ok = bus.prov_we && (pc < n_users);
    commit  = (ph == P_SESS) && bus.op_done;
    x_wrong = 0; x_to = 0;
    case (ph)
      P_IDLE: if (bus.card_in) begin
        cur = int'(bus.card_number);
        if (cur >= n_users) begin ph = P_OUT; x_inv = 1; end
        else if (m_lock[cur]) begin ph = P_OUT; x_lock = 1; end
        else begin ph = P_PIN; idle = 0; x_tries = mt - m_fail[cur]; end
      end
      P_PIN: begin
        if (!bus.card_in) card_out();
        else if (bus.pin_valid) begin
          idle = 0;
          if (bus.password_input == m_pwd[cur]) begin
            ph = P_SESS; x_auth = 1; x_bal = m_bal[cur]; m_fail[cur] = 0; x_tries = mt;
          end else begin
            m_fail[cur]++; x_wrong = 1; x_tries = mt - m_fail[cur];
            if (m_fail[cur] == mt) begin m_lock[cur] = 1; ph = P_OUT; x_lock = 1; end
          end
        end else begin
          idle++;
          if (idle == to_cyc) begin x_to = 1; ph = P_OUT; end
        end
      end
      P_SESS: begin
        if (bus.op_done) begin x_bal = bus.updated_balance; idle = 0; end
        if (!bus.card_in) card_out();
        else if (!bus.op_done) begin
          idle++;
          if (idle == to_cyc) begin x_to = 1; ph = P_OUT; x_auth = 0; x_bal = '0; end
        end
      end
      default: if (!bus.card_in) card_out();
    endcase
    if (commit && !(prov_ok && pc == cur)) m_bal[cur] = bus.updated_balance;
    if (prov_ok) begin
      m_pwd[pc] = bus.prov_password; m_bal[pc] = bus.prov_balance;
      m_fail[pc] = 0; m_lock[pc] = 0;
      if (ph == P_SESS && pc == cur) x_bal = bus.prov_balance;
    end
  endtask

  task automatic compare_model();
    chk("model_auth_ok", bus.auth_ok, x_auth);
    chk("model_balance", bus.balance, x_bal);
    chk("model_wrong_psw", bus.wrong_psw, x_wrong);
    chk("model_card_locked", bus.card_locked, x_lock);
    chk("model_invalid_card", bus.invalid_card, x_inv);
    chk("model_timeout", bus.timeout, x_to);
    chk("model_tries_left", bus.tries_left, 32'(x_tries));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare_model();
  endtask

  task automatic insert(input int c);
    bus.card_in = 1'b1; bus.card_number = 4'(c); cycle();
  endtask
  task automatic enter_pin(input logic [15:0] p);
    bus.pin_valid = 1'b1; bus.password_input = p; cycle(); bus.pin_valid = 1'b0;
  endtask
  task automatic remove();
    bus.card_in = 1'b0; cycle();
  endtask
  task automatic login(input int c);
    insert(c); enter_pin(m_pwd[c]);
  endtask

  typedef struct {
    logic ci; logic [3:0] cn; logic pv; logic [15:0] pw; logic od; logic [19:0] ub;
    logic pwe; logic [3:0] pc; logic [15:0] pp; logic [19:0] pb;
    logic e_auth; logic [19:0] e_bal; logic e_wrong; logic e_lock; logic e_inv; logic [2:0] e_tries;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t v(input int ci, cn, pv, pw, od, ub, pwe, pc, pp, pb,
                             input int ea, eb, ew, el, ei, et);
    vec_t r;
    r.ci = 1'(ci); r.cn = 4'(cn); r.pv = 1'(pv); r.pw = 16'(pw); r.od = 1'(od); r.ub = 20'(ub);
    r.pwe = 1'(pwe); r.pc = 4'(pc); r.pp = 16'(pp); r.pb = 20'(pb);
    r.e_auth = 1'(ea); r.e_bal = 20'(eb); r.e_wrong = 1'(ew); r.e_lock = 1'(el);
    r.e_inv = 1'(ei); r.e_tries = 3'(et);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hit;
    rst = 1'b1;
    bus.card_in = 0; bus.card_number = 0; bus.pin_valid = 0; bus.password_input = 0;
    bus.op_done = 0; bus.updated_balance = 0; bus.prov_we = 0; bus.prov_card = 0;
    bus.prov_password = 0; bus.prov_balance = 0;
    for (int i = 0; i < 16; i++) begin m_pwd[i] = '0; m_bal[i] = '0; end
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;

    // Provision every user; card 2 carries the PIN/balance used by the directed table.
    for (int c = 0; c < n_users; c++) begin
      bus.prov_we = 1; bus.prov_card = 4'(c);
      bus.prov_password = (c == 2) ? 16'h1234 : 16'(16'hA000 + c);
      bus.prov_balance  = (c == 2) ? 20'd500 : 20'(100 * c);
      cycle();
    end
    bus.prov_we = 0;

    //            ci cn pv pw       od ub   pwe pc pp      pb    auth bal  wr lk inv tries
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 3));
    tbl.push_back(v(1, 2, 1, 16'h1234, 0, 0,  0, 0, 0,      0,    1, 500,  0, 0, 0, 3));
    tbl.push_back(v(1, 2, 0, 0,       1, 300, 0, 0, 0,      0,    1, 300,  0, 0, 0, 3));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 3));
    tbl.push_back(v(1, 2, 1, 16'h1234, 0, 0,  0, 0, 0,      0,    1, 300,  0, 0, 0, 3));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 3));
    tbl.push_back(v(1, 2, 1, bad_pin, 0, 0,   0, 0, 0,      0,    0, 0,    1, 0, 0, 2));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 2));
    tbl.push_back(v(1, 2, 1, bad_pin, 0, 0,   0, 0, 0,      0,    0, 0,    1, 0, 0, 1));
    tbl.push_back(v(1, 2, 1, bad_pin, 0, 0,   0, 0, 0,      0,    0, 0,    1, 1, 0, 0));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 1, 0, 0));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 1, 0, 0));
    tbl.push_back(v(1, 2, 1, 16'h1234, 0, 0,  0, 0, 0,      0,    0, 0,    0, 1, 0, 0));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   1, 2, 16'h1234, 777, 0, 0,   0, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 3));
    tbl.push_back(v(1, 2, 1, 16'h1234, 0, 0,  0, 0, 0,      0,    1, 777,  0, 0, 0, 3));
    tbl.push_back(v(0, 2, 0, 0,       0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));
    tbl.push_back(v(1, 12, 0, 0,      0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 1, 0));
    tbl.push_back(v(1, 12, 1, 16'h1234, 0, 0, 0, 0, 0,      0,    0, 0,    0, 0, 1, 0));
    tbl.push_back(v(0, 12, 0, 0,      0, 0,   0, 0, 0,      0,    0, 0,    0, 0, 0, 0));

    foreach (tbl[i]) begin
      bus.card_in = tbl[i].ci; bus.card_number = tbl[i].cn;
      bus.pin_valid = tbl[i].pv; bus.password_input = tbl[i].pw;
      bus.op_done = tbl[i].od; bus.updated_balance = tbl[i].ub;
      bus.prov_we = tbl[i].pwe; bus.prov_card = tbl[i].pc;
      bus.prov_password = tbl[i].pp; bus.prov_balance = tbl[i].pb;
      cycle();
      chk($sformatf("tbl%0d_auth_ok", i), bus.auth_ok, tbl[i].e_auth);
      chk($sformatf("tbl%0d_balance", i), bus.balance, tbl[i].e_bal);
      chk($sformatf("tbl%0d_wrong_psw", i), bus.wrong_psw, tbl[i].e_wrong);
      chk($sformatf("tbl%0d_card_locked", i), bus.card_locked, tbl[i].e_lock);
      chk($sformatf("tbl%0d_invalid_card", i), bus.invalid_card, tbl[i].e_inv);
      chk($sformatf("tbl%0d_tries_left", i), bus.tries_left, tbl[i].e_tries);
    end
    bus.pin_valid = 0; bus.op_done = 0; bus.prov_we = 0;

    // Idle in WAIT_PIN: the timeout pulse lands on the 1000th idle cycle and lasts one cycle.
    insert(3);
    hit = 0;
    for (int k = 1; k <= to_cyc + 100 && hit == 0; k++) begin
      cycle();
      if (bus.timeout) hit = k;
    end
    chk("wait_timeout_cycle", 32'(hit), 32'(to_cyc));
    cycle();
    chk("wait_timeout_pulse_width", bus.timeout, 0);
    chk("wait_timeout_ejected_auth", bus.auth_ok, 0);
    remove();

    // Idle in SESSION: timeout drops the balance back to zero.
    login(3);
    chk("sess_balance_before_timeout", bus.balance, 300);
    hit = 0;
    for (int k = 1; k <= to_cyc + 100 && hit == 0; k++) begin
      cycle();
      if (bus.timeout) hit = k;
    end
    chk("sess_timeout_cycle", 32'(hit), 32'(to_cyc));
    chk("sess_timeout_balance", bus.balance, 0);
    chk("sess_timeout_auth_ok", bus.auth_ok, 0);
    remove();

    // PIN on the very cycle the timeout would fire: the PIN wins.
    insert(3);
    repeat (to_cyc - 1) cycle();
    enter_pin(m_pwd[3]);
    chk("pin_beats_timeout_auth", bus.auth_ok, 1);
    chk("pin_beats_timeout_flag", bus.timeout, 0);
    remove();

    // Commit together with card removal still lands.
    login(5);
    bus.card_in = 0; bus.op_done = 1; bus.updated_balance = 20'd4242;
    cycle();
    bus.op_done = 0;
    chk("commit_on_remove_balance_out", bus.balance, 0);
    login(5);
    chk("commit_on_remove_persisted", bus.balance, 4242);
    remove();

    // Provisioning collides with op_done on the session card: provisioning wins.
    login(6);
    bus.op_done = 1; bus.updated_balance = 20'd111;
    bus.prov_we = 1; bus.prov_card = 4'd6; bus.prov_password = m_pwd[6]; bus.prov_balance = 20'd999;
    cycle();
    bus.op_done = 0; bus.prov_we = 0;
    chk("prov_vs_op_done_balance", bus.balance, 999);
    remove();
    login(6);
    chk("prov_vs_op_done_persisted", bus.balance, 999);
    remove();

    // Asynchronous reset mid-session drops the pending commit and the fail history.
    insert(7); enter_pin(16'(bad_pin)); remove();
    login(4);
    chk("pre_reset_auth_ok", bus.auth_ok, 1);
    bus.op_done = 1; bus.updated_balance = 20'd12345;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_auth_ok", bus.auth_ok, 0);
    chk("async_reset_balance", bus.balance, 0);
    chk("async_reset_tries_left", bus.tries_left, 0);
    cycle();
    bus.op_done = 0; bus.card_in = 0;
    rst = 1'b0;
    cycle();
    login(4);
    chk("reset_lost_commit", bus.balance, 400);
    remove();
    insert(7);
    chk("reset_cleared_fail_count", bus.tries_left, 3);
    remove();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (bus.card_in) begin
        if ($urandom_range(0, 24) == 0) bus.card_in = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        bus.card_in = 1;
      end
      bus.card_number     = 4'($urandom_range(0, 12));
      bus.pin_valid       = ($urandom_range(0, 5) == 0);
      bus.password_input  = ($urandom_range(0, 1) == 1) ? m_pwd[cur] : 16'($urandom);
      bus.op_done         = ($urandom_range(0, 4) == 0);
      bus.updated_balance = 20'($urandom);
      bus.prov_we         = ($urandom_range(0, 29) == 0);
      bus.prov_card       = 4'($urandom_range(0, 15));
      bus.prov_password   = 16'($urandom);
      bus.prov_balance    = 20'($urandom);
      cycle();
    end
    bus.pin_valid = 0; bus.op_done = 0; bus.prov_we = 0; bus.card_in = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
